hyperbus_arbiter: RTL

Two-port round-robin arbiter and burst sequencer in front of the `hyperbus` controller. It grants one requester at a time. For the granted port it latches the command, holds the controller's `rrq`/`wrq` for exactly the requested number of 16-bit words, and steers write data, masks and read data. It then enforces an idle gap so the controller returns to IDLE before the next grant. A watchdog aborts reads that stall, so a missing `valid` cannot hang the bus.

---
 rtl/hyperbus_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/hyperbus_arbiter.sv
// Two-port round-robin arbiter and burst sequencer in front of the hyperbus
// controller. One port is granted at a time. Its command is latched, rrq/wrq
// is held for the requested word count, and an idle gap follows each burst.
// A stall watchdog aborts bursts whose beats stop arriving.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no burst; arbitrate between p0/p1, tie goes opposite last_grant
// XFER  | burst active; hb_*rq asserted, count beats, run stall watchdog
// GAP   | hb_*rq low for GAP_CYCLES so the controller settles in IDLE
module hyperbus_arbiter #(
  parameter int WIDTH       = 8,
  parameter int ADDR_LENGTH = 32,
  parameter int LEN_WIDTH   = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                     clk,
  input  logic                     rstn,

  input  logic                     p0_req,
  input  logic                     p0_we,
  input  logic                     p0_reg_space,
  input  logic [ADDR_LENGTH-1:0]   p0_adr,
  input  logic [LEN_WIDTH-1:0]     p0_len,
  input  logic [2*WIDTH-1:0]       p0_wdat,
  input  logic [2*WIDTH/8-1:0]     p0_wmask,
  output logic                     p0_wready,
  output logic [2*WIDTH-1:0]       p0_rdat,
  output logic                     p0_rvalid,
  output logic                     p0_done,
  output logic                     p0_err,

  input  logic                     p1_req,
  input  logic                     p1_we,
  input  logic                     p1_reg_space,
  input  logic [ADDR_LENGTH-1:0]   p1_adr,
  input  logic [LEN_WIDTH-1:0]     p1_len,
  input  logic [2*WIDTH-1:0]       p1_wdat,
  input  logic [2*WIDTH/8-1:0]     p1_wmask,
  output logic                     p1_wready,
  output logic [2*WIDTH-1:0]       p1_rdat,
  output logic                     p1_rvalid,
  output logic                     p1_done,
  output logic                     p1_err,

  output logic [ADDR_LENGTH-1:0]   hb_adr,
  output logic                     hb_reg_space,
  output logic                     hb_wrq,
  output logic                     hb_rrq,
  output logic [2*WIDTH-1:0]       hb_dat_i,
  output logic [2*WIDTH/8-1:0]     hb_mask,
  input  logic [2*WIDTH-1:0]       hb_dat_o,
  input  logic                     hb_ready,
  input  logic                     hb_valid
);

  localparam int MW  = 2*WIDTH/8;
  localparam int WDW = $clog2(TIMEOUT+1);
  localparam int GW  = $clog2(GAP_CYCLES+1);

  localparam logic [LEN_WIDTH:0] REM_ONE  = 1;
  localparam logic [WDW-1:0]     WD_LAST  = WDW'(TIMEOUT-1);
  localparam logic [GW-1:0]      GAP_LOAD = GW'(GAP_CYCLES-1);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_e;

  state_e                 state_q, state_d;
  logic                   grant_q, grant_d;
  logic                   last_grant_q, last_grant_d;
  logic                   we_q, we_d;
  logic                   reg_space_q, reg_space_d;
  logic [ADDR_LENGTH-1:0] adr_q, adr_d;
  logic [LEN_WIDTH:0]     rem_q, rem_d;
  logic [WDW-1:0]         wd_q, wd_d;
  logic [GW-1:0]          gap_q, gap_d;

  logic                   xfer, beat_w, beat_r, beat, last_beat, expire, done;
  logic                   gsel;
  logic [LEN_WIDTH-1:0]   sel_len;

  // State and latched command registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      reg_space_q  <= 1'b0;
      adr_q        <= '0;
      rem_q        <= '0;
      wd_q         <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      reg_space_q  <= reg_space_d;
      adr_q        <= adr_d;
      rem_q        <= rem_d;
      wd_q         <= wd_d;
      gap_q        <= gap_d;
    end
  end

  // Arbitration, beat counting, watchdog and output steering.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    reg_space_d  = reg_space_q;
    adr_d        = adr_q;
    rem_d        = rem_q;
    wd_d         = wd_q;
    gap_d        = gap_q;
    gsel         = 1'b0;
    sel_len      = '0;

    xfer      = (state_q == XFER);
    beat_w    = xfer &  we_q & hb_ready;
    beat_r    = xfer & ~we_q & hb_valid;
    beat      = beat_w | beat_r;
    last_beat = beat & (rem_q == REM_ONE);
    // a beat always wins over a coincident watchdog expiry
    expire    = xfer & ~beat & (wd_q == WD_LAST);
    done      = last_beat | expire;

    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          gsel         = (p0_req && p1_req) ? ~last_grant_q : p1_req;
          sel_len      = gsel ? p1_len : p0_len;
          grant_d      = gsel;
          last_grant_d = gsel;
          we_d         = gsel ? p1_we : p0_we;
          reg_space_d  = gsel ? p1_reg_space : p0_reg_space;
          adr_d        = gsel ? p1_adr : p0_adr;
          rem_d        = (sel_len == '0) ? REM_ONE : {1'b0, sel_len};
          wd_d         = '0;
          state_d      = XFER;
        end
      end
      XFER: begin
        if (beat) begin
          rem_d = rem_q - 1'b1;
          wd_d  = '0;
        end else if (!expire) begin
          wd_d = wd_q + 1'b1;
        end
        if (done) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    hb_wrq       = xfer &  we_q;
    hb_rrq       = xfer & ~we_q;
    hb_adr       = xfer ? adr_q : '0;
    hb_reg_space = xfer & reg_space_q;
    hb_dat_i     = xfer ? (grant_q ? p1_wdat  : p0_wdat)  : '0;
    hb_mask      = xfer ? (grant_q ? p1_wmask : p0_wmask) : {MW{1'b0}};

    p0_wready = beat_w & ~grant_q;
    p0_rvalid = beat_r & ~grant_q;
    p0_done   = done   & ~grant_q;
    p0_err    = expire & ~grant_q;
    p1_wready = beat_w &  grant_q;
    p1_rvalid = beat_r &  grant_q;
    p1_done   = done   &  grant_q;
    p1_err    = expire &  grant_q;
    p0_rdat   = hb_dat_o;
    p1_rdat   = hb_dat_o;
  end

endmodule
